// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit front-end for an RV32I data memory.
//
// Accepts one load/store from the execution stage and computes ea = rs1 + imm.
// It issues one request on the data-memory bus, and then returns the
// sign/zero-extended load result on the writeback port. If the memory does
// not answer within TIMEOUT cycles, the access is abandoned and a fault is
// reported. Illegal func3 codes are also reported as faults.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_store, func3         operation kind and RV32I width/sign code
//   rs1, imm, store_data, rd operands of the load/store
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb   memory request bus
//   mem_rdata, mem_ack       memory response
//   wb_valid, wb_rd, wb_data registered load writeback (one-cycle pulse)
//   fault, fault_addr        one-cycle fault pulse and offending address
//
// Build option
//   MISALIGN_TRAP_EN  defined: misaligned half/word requests fault.
//                     undefined: the address is forced to alignment and the
//                     access proceeds.

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  func3,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [31:0] fault_addr
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] ea_q, ea_acc, sdata_q, ld_data;
    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        store_q;

    logic [31:0] ea;
    logic        illegal, misalign, req_fault, req_fire, timeout_hit;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign ea          = rs1 + imm;
    assign req_fire    = req_valid && (state == IDLE);
    assign timeout_hit = (cnt == TLAST);

    always_comb begin
        illegal  = req_store ? (func3 > 3'd2)
                             : (func3 == 3'b011 || func3[2:1] == 2'b11);
        misalign = (func3[1:0] == 2'b01 && ea[0]) ||
                   (func3[1:0] == 2'b10 && ea[1:0] != 2'b00);
        req_fault = illegal || (TRAP_MISALIGN && misalign);
    end

    // With trapping enabled, nothing misaligned ever reaches ACCESS, so the
    // alignment mask is a no-op there; with it disabled, it forces alignment.
    always_comb begin
        ea_acc = ea_q;
        case (func3_q[1:0])
            2'b01:   ea_acc[0]   = 1'b0;
            2'b10:   ea_acc[1:0] = 2'b00;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (req_valid && !req_fault) state_nxt = ACCESS;
            ACCESS: if (mem_ack || timeout_hit)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the memory bus is driven only while in ACCESS
    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state == ACCESS) begin
            mem_req  = 1'b1;
            mem_we   = store_q;
            mem_addr = {ea_acc[31:2], 2'b00};
            if (store_q) begin
                case (func3_q[1:0])
                    2'b00: begin
                        mem_wstrb = 4'b0001 << ea_acc[1:0];
                        mem_wdata = {4{sdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_wstrb = 4'b0011 << {ea_acc[1], 1'b0};
                        mem_wdata = {2{sdata_q[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = sdata_q;
                    end
                endcase
            end
        end
    end

    // Load lane extraction and extension
    always_comb begin
        case (ea_acc[1:0])
            2'b00:   lane_b = mem_rdata[7:0];
            2'b01:   lane_b = mem_rdata[15:8];
            2'b10:   lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = ea_acc[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_data = {24'd0, lane_b};
            3'b101:  ld_data = {16'd0, lane_h};
            default: ld_data = mem_rdata;
        endcase
    end

    // Request latch, timeout counter, writeback and fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            ea_q       <= '0;
            func3_q    <= '0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            sdata_q    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            if (req_fire) begin
                if (req_fault) begin
                    fault      <= 1'b1;
                    fault_addr <= ea;
                end else begin
                    cnt     <= '0;
                    ea_q    <= ea;
                    func3_q <= func3;
                    rd_q    <= rd;
                    store_q <= req_store;
                    sdata_q <= store_data;
                end
            end else if (state == ACCESS) begin
                // An ack arriving on the final counted cycle wins over timeout
                if (mem_ack) begin
                    if (!store_q && rd_q != 5'd0) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ld_data;
                    end
                end else if (timeout_hit) begin
                    fault      <= 1'b1;
                    fault_addr <= ea_q;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  func3;
    logic [31:0] rs1, imm, store_data;
    logic [4:0]  rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .func3(func3), .rs1(rs1), .imm(imm), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned op_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_illegal(input bit st, input logic [2:0] f3);
        if (st) return f3 > 3'd2;
        return (f3 == 3'd3) || (f3 >= 3'd6);
    endfunction

    function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        if (m_illegal(st, f3)) return 1'b1;
        return TRAP && ((ea % op_bytes(f3)) != 0);
    endfunction

    function automatic logic [31:0] m_eff(input logic [2:0] f3, input logic [31:0] ea);
        return ea - (ea % op_bytes(f3));
    endfunction

    function automatic logic [3:0] m_wstrb(input bit st, input logic [2:0] f3, input logic [31:0] eff);
        int unsigned m;
        if (!st) return 4'd0;
        m = ((1 << op_bytes(f3)) - 1) << (eff % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input bit st, input logic [2:0] f3, input logic [31:0] sd);
        if (!st) return 32'd0;
        case (op_bytes(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] eff, input logic [31:0] rdata);
        logic [31:0] v;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        v  = rdata >> (8 * (eff % 4));
        sb = v[7:0];
        sh = v[15:0];
        case (f3)
            3'd0:    return int'(sb);
            3'd1:    return int'(sh);
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        req_valid = 1'b0; req_store = 1'b0; func3 = '0;
        rs1 = '0; imm = '0; store_data = '0; rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // One transaction; ack_at is the 0-based ACCESS cycle that gets mem_ack
    // (ack_at >= TO means the ack is withheld).
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] sd, input logic [4:0] r,
                          input logic [31:0] rdata, input int ack_at);
        logic [31:0] ea, eff, exp_addr, exp_ld;
        bit exp_f, exp_wbv;
        ea       = a + b;
        exp_f    = m_fault(st, f3, ea);
        eff      = m_eff(f3, ea);
        exp_addr = eff & 32'hFFFF_FFFC;
        exp_wbv  = !st && (r != 5'd0);
        exp_ld   = m_load(f3, eff, rdata);

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL ready_idle: req_ready=%b expected 1", req_ready);
        if (req_ready !== 1'b1) errors++;
        req_valid = 1'b1; req_store = st; func3 = f3; rs1 = a; imm = b;
        store_data = sd; rd = r;
        @(negedge clk);
        req_valid = 1'b0; rs1 = $urandom; imm = $urandom; store_data = $urandom;

        if (exp_f) begin
            checks++;
            if (fault !== 1'b1 || fault_addr !== ea || mem_req !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL req_fault: fault=%b addr=%h req=%b rdy=%b expected 1 %h 0 1",
                         fault, fault_addr, mem_req, req_ready, ea);
            end
            @(negedge clk);
            checks++;
            if (fault !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL fault_pulse: fault=%b req=%b expected 0 0", fault, mem_req);
            end
            return;
        end

        for (int k = 0; k < int'(TO); k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== st ||
                mem_wstrb !== m_wstrb(st, f3, eff) || mem_wdata !== m_wdata(st, f3, sd) ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL access: req=%b addr=%h we=%b strb=%b wdata=%h rdy=%b expected 1 %h %b %b %h 0",
                         mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata, req_ready,
                         exp_addr, st, m_wstrb(st, f3, eff), m_wdata(st, f3, sd));
            end
            if (k == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rdata;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                checks++;
                if (wb_valid !== exp_wbv || req_ready !== 1'b1 || mem_req !== 1'b0 || fault !== 1'b0) begin
                    errors++;
                    $display("FAIL complete: wbv=%b rdy=%b req=%b fault=%b expected %b 1 0 0",
                             wb_valid, req_ready, mem_req, fault, exp_wbv);
                end
                if (exp_wbv) begin
                    checks++;
                    if (wb_data !== exp_ld || wb_rd !== r) begin
                        errors++;
                        $display("FAIL wb_data: data=%h rd=%0d expected %h %0d", wb_data, wb_rd, exp_ld, r);
                    end
                end
                @(negedge clk);
                checks++;
                if (wb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_pulse: wb_valid=%b expected 0", wb_valid);
                end
                return;
            end
            @(negedge clk);
        end

        checks++;
        if (fault !== 1'b1 || fault_addr !== ea || mem_req !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout: fault=%b addr=%h req=%b wbv=%b rdy=%b expected 1 %h 0 0 1",
                     fault, fault_addr, mem_req, wb_valid, req_ready, ea);
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: fault=%b expected 0", fault);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
            mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 ||
            wb_data !== 32'd0 || fault !== 1'b0 || fault_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b req=%b we=%b addr=%h wd=%h strb=%b wbv=%b rd=%0d wbd=%h f=%b fa=%h expected all 0 except rdy=1",
                     req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                     wb_valid, wb_rd, wb_data, fault, fault_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd7, 32'h80FF_FF7F, 0);       // LB sign
        run_op(1'b1, 3'b001, 32'h200, 32'h2, 32'h1234_ABCD, 5'd3, 32'h0, 0);     // SH upper half
        run_op(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd9, 32'hDEAD_BEEF, 0); // LW wrap
        run_op(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd4, 32'hCAFE_F00D, 1);     // LW ea=0x102
        run_op(1'b0, 3'b100, 32'h40, 32'h1, 32'h0, 5'd5, 32'h0000_9A00, 0);      // LBU
        run_op(1'b0, 3'b101, 32'h40, 32'h2, 32'h0, 5'd6, 32'h8001_0000, 0);      // LHU
        run_op(1'b1, 3'b000, 32'h3, 32'h0, 32'h0000_00A5, 5'd0, 32'h0, 2);        // SB lane 3
    endtask

    task automatic test_illegal();
        run_op(1'b0, 3'b011, 32'h1000, 32'h4, 32'h0, 5'd1, 32'h0, 0);
        run_op(1'b0, 3'b110, 32'h1000, 32'h8, 32'h0, 5'd1, 32'h0, 0);
        run_op(1'b1, 3'b100, 32'h2000, 32'h0, 32'h5, 5'd1, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd2, 32'h1111_2222, int'(TO) + 3); // withheld
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 5'd2, 32'h3333_4444, int'(TO) - 1); // last cycle
        run_op(1'b1, 3'b010, 32'h308, 32'h0, 32'h55AA_55AA, 5'd2, 32'h0, int'(TO));
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; func3 = 3'b010; rs1 = 32'h500; imm = 32'h0; rd = 5'd8;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_access: mem_req=%b expected 1", mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        checks++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 || fault !== 1'b0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_abort: rdy=%b req=%b wbv=%b fault=%b addr=%h expected 1 0 0 0 0",
                     req_ready, mem_req, wb_valid, fault, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || mem_req !== 1'b0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL late_ack: wbv=%b req=%b wbd=%h expected 0 0 0", wb_valid, mem_req, wb_data);
        end
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0 || mem_req !== 1'b0 || fault !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL ack_idle: wbv=%b req=%b fault=%b rdy=%b expected 0 0 0 1",
                         wb_valid, mem_req, fault, req_ready);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic rand_op(input int ack_at);
        bit st;
        logic [2:0] f3;
        logic [4:0] r;
        st = 1'($urandom);
        if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
        else if (st) f3 = 3'($urandom_range(0, 2));
        else begin
            case ($urandom_range(0, 4))
                0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
        end
        r = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        run_op(st, f3, $urandom, $urandom, $urandom, r, $urandom, ack_at);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) rand_op($urandom_range(0, TO + 1));
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) rand_op(0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_ack_idle();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
